// File: rtl/tri_feeder_pkg.sv
// tri_feeder shared types: vertex bundle, mesh word layout, FSM states.
// Also holds the signed-area helper used by the optional back-face cull.
package tri_feeder_pkg;

    // vertex as {x, y, z}: index 0 = z, 1 = y, 2 = x
    typedef logic [2:0][8:0] vert_t;

    // 27-bit mesh word field offsets
    localparam int FLD_W = 9;
    localparam int X_LSB = 0;
    localparam int Y_LSB = 9;
    localparam int Z_LSB = 18;

    // feeder FSM encoding
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_FETCH   = 3'd1;
    localparam state_t S_CULL    = 3'd2;
    localparam state_t S_PRESENT = 3'd3;
    localparam state_t S_DONE    = 3'd4;

    function automatic vert_t unpack_word(input logic [26:0] w);
        vert_t v;
        v[0] = w[Z_LSB +: FLD_W];
        v[1] = w[Y_LSB +: FLD_W];
        v[2] = w[X_LSB +: FLD_W];
        return v;
    endfunction

    // A = (x2-x1)*(y3-y1) - (y2-y1)*(x3-x1)
    function automatic logic signed [20:0] tri_area(
        input vert_t a,
        input vert_t b,
        input vert_t c
    );
        logic signed [9:0] dx21;
        logic signed [9:0] dy31;
        logic signed [9:0] dy21;
        logic signed [9:0] dx31;
        logic signed [20:0] p;
        logic signed [20:0] q;
        dx21 = $signed({1'b0, b[2]}) - $signed({1'b0, a[2]});
        dy31 = $signed({1'b0, c[1]}) - $signed({1'b0, a[1]});
        dy21 = $signed({1'b0, b[1]}) - $signed({1'b0, a[1]});
        dx31 = $signed({1'b0, c[2]}) - $signed({1'b0, a[2]});
        p = 21'(dx21) * 21'(dy31);
        q = 21'(dy21) * 21'(dx31);
        return p - q;
    endfunction

endpackage

// File: rtl/tri_feeder.sv
// tri_feeder: streams an object's triangles from mesh ROM to the rasterizer.
// Define TRI_FEEDER_BACKFACE_CULL_EN to drop triangles with area <= 0.
module tri_feeder
    import tri_feeder_pkg::*;
#(
    parameter int NUM_TRIS    = 12,
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = $clog2(3 * NUM_TRIS)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              new_frame,
    input  logic              ready_in,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [26:0]       mem_data,
    output logic [2:0][8:0]   vert1,
    output logic [2:0][8:0]   vert2,
    output logic [2:0][8:0]   vert3,
    output logic              valid_tri,
    output logic              obj_done,
    output logic              busy
);

    localparam int IDX_W = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1;
    localparam int CNT_W = $clog2(MEM_LATENCY + 3);

    state_t             state;
    logic [IDX_W-1:0]   tri_idx;
    logic [CNT_W-1:0]   cnt;
    logic               last_tri;
    logic               skip_tri;
    logic [ADDR_W-1:0]  next_base;
    vert_t              word_v;

    assign last_tri  = (tri_idx == IDX_W'(NUM_TRIS - 1));
    assign next_base = ADDR_W'(3 * (int'(tri_idx) + 1));
    assign word_v    = unpack_word(mem_data);

`ifdef TRI_FEEDER_BACKFACE_CULL_EN
    logic signed [20:0] area;
    assign area     = tri_area(vert1, vert2, vert3);
    assign skip_tri = (area <= 21'sd0);
`else
    assign skip_tri = 1'b0;
`endif

    // status flags decoded straight from the state register
    always_comb begin
        busy     = (state != S_IDLE);
        obj_done = (state == S_DONE);
    end

    // fetch three words, optionally cull, then hold until accepted
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            tri_idx   <= '0;
            cnt       <= '0;
            mem_addr  <= '0;
            valid_tri <= 1'b0;
            vert1     <= '0;
            vert2     <= '0;
            vert3     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (new_frame) begin
                        state    <= S_FETCH;
                        tri_idx  <= '0;
                        cnt      <= '0;
                        mem_addr <= '0;
                    end
                end
                S_FETCH: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt < CNT_W'(2))
                        mem_addr <= mem_addr + ADDR_W'(1);
                    if (cnt == CNT_W'(MEM_LATENCY))
                        vert1 <= word_v;
                    if (cnt == CNT_W'(MEM_LATENCY + 1))
                        vert2 <= word_v;
                    if (cnt == CNT_W'(MEM_LATENCY + 2)) begin
                        vert3 <= word_v;
                        state <= S_CULL;
                    end
                end
                S_CULL: begin
                    if (!skip_tri) begin
                        valid_tri <= 1'b1;
                        state     <= S_PRESENT;
                    end else if (last_tri) begin
                        state <= S_DONE;
                    end else begin
                        tri_idx  <= tri_idx + IDX_W'(1);
                        cnt      <= '0;
                        mem_addr <= next_base;
                        state    <= S_FETCH;
                    end
                end
                S_PRESENT: begin
                    if (ready_in) begin
                        valid_tri <= 1'b0;
                        if (last_tri) begin
                            state <= S_DONE;
                        end else begin
                            tri_idx  <= tri_idx + IDX_W'(1);
                            cnt      <= '0;
                            mem_addr <= next_base;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    valid_tri <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_feeder.sv
// tb_tri_feeder: directed bench for tri_feeder with a 2-cycle ROM model.
// NUM_TRIS=2; cull scenarios build only with TRI_FEEDER_BACKFACE_CULL_EN.
module tb_tri_feeder;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            new_frame;
    logic            ready_in;
    logic [2:0]      mem_addr;
    logic [26:0]     mem_data;
    logic [2:0][8:0] vert1;
    logic [2:0][8:0] vert2;
    logic [2:0][8:0] vert3;
    logic            valid_tri;
    logic            obj_done;
    logic            busy;

    logic [26:0] rom [8];
    logic [26:0] d1;
    logic [26:0] d2;

    int total = 0;
    int bad = 0;
    int xfers = 0;
    int dones = 0;
    int vcycles = 0;

    tri_feeder #(
        .NUM_TRIS(2),
        .MEM_LATENCY(2)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .new_frame(new_frame),
        .ready_in(ready_in),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .vert1(vert1),
        .vert2(vert2),
        .vert3(vert3),
        .valid_tri(valid_tri),
        .obj_done(obj_done),
        .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    // two-stage registered ROM
    always @(posedge clk_in) begin
        d1 <= rom[mem_addr];
        d2 <= d1;
    end
    assign mem_data = d2;

    // handshake and pulse monitors
    always @(posedge clk_in) begin
        if (!rst_in) begin
            if (valid_tri && ready_in) xfers++;
            if (obj_done) dones++;
            if (valid_tri) vcycles++;
        end
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [26:0] mkw(input int x, input int y, input int z);
        return {9'(z), 9'(y), 9'(x)};
    endfunction

    function automatic logic [26:0] expv(input int x, input int y, input int z);
        return {9'(x), 9'(y), 9'(z)};
    endfunction

    // z of vertex k of triangle t is 3*t+k+1
    task automatic load_tri(input int t, input int x1, input int y1,
                            input int x2, input int y2,
                            input int x3, input int y3);
        rom[3*t]   = mkw(x1, y1, 3*t + 1);
        rom[3*t+1] = mkw(x2, y2, 3*t + 2);
        rom[3*t+2] = mkw(x3, y3, 3*t + 3);
    endtask

    task automatic pulse_frame;
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (valid_tri === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (obj_done === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        new_frame = 1'b0;
        ready_in = 1'b0;
        for (int i = 0; i < 8; i++) rom[i] = '0;
        tick();
        tick();
        total++;
        if (valid_tri !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", valid_tri);
        end
        total++;
        if (obj_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b want=0", obj_done);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        total++;
        if (mem_addr !== 3'd0) begin
            bad++;
            $display("FAIL reset_addr got=%0d want=0", mem_addr);
        end
        total++;
        if ({vert1, vert2, vert3} !== 81'd0) begin
            bad++;
            $display("FAIL reset_verts got=%h want=0", {vert1, vert2, vert3});
        end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_stream;
        int d0;
        int x0;
        bit ok;
        load_tri(0, 1, 2, 11, 2, 1, 12);
        load_tri(1, 100, 50, 200, 50, 100, 150);
        ready_in = 1'b1;
        d0 = dones;
        x0 = xfers;
        pulse_frame();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (mem_addr !== 3'(k)) begin
                bad++;
                $display("FAIL stream_addr%0d got=%0d want=%0d", k, mem_addr, k);
            end
            tick();
        end
        tick();
        tick();
        total++;
        if (valid_tri !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stream_t6 got valid=%b busy=%b want 0 1", valid_tri, busy);
        end
        tick();
        total++;
        if (valid_tri !== 1'b1) begin
            bad++;
            $display("FAIL stream_t7_valid got=%b want=1", valid_tri);
        end
        total++;
        if (vert1 !== expv(1, 2, 1) || vert2 !== expv(11, 2, 2) || vert3 !== expv(1, 12, 3)) begin
            bad++;
            $display("FAIL stream_tri0 got=%h %h %h want=%h %h %h", vert1, vert2, vert3,
                     expv(1, 2, 1), expv(11, 2, 2), expv(1, 12, 3));
        end
        tick();
        total++;
        if (valid_tri !== 1'b0 || mem_addr !== 3'd3) begin
            bad++;
            $display("FAIL stream_t8 got valid=%b addr=%0d want 0 3", valid_tri, mem_addr);
        end
        wait_valid(20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stream_tri1_timeout got=none want=valid");
        end
        total++;
        if (vert1 !== expv(100, 50, 4) || vert2 !== expv(200, 50, 5) || vert3 !== expv(100, 150, 6)) begin
            bad++;
            $display("FAIL stream_tri1 got=%h %h %h want=%h %h %h", vert1, vert2, vert3,
                     expv(100, 50, 4), expv(200, 50, 5), expv(100, 150, 6));
        end
        wait_done(20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stream_done_timeout got=none want=obj_done");
        end
        tick();
        total++;
        if (obj_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stream_after got done=%b busy=%b want 0 0", obj_done, busy);
        end
        total++;
        if (dones - d0 != 1 || xfers - x0 != 2) begin
            bad++;
            $display("FAIL stream_counts got done=%0d xfer=%0d want 1 2", dones - d0, xfers - x0);
        end
    endtask

    task automatic test_stall;
        int d0;
        int x0;
        bit ok;
        ready_in = 1'b0;
        d0 = dones;
        x0 = xfers;
        pulse_frame();
        wait_valid(20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stall_timeout got=none want=valid");
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({valid_tri, vert1, vert2, vert3} !==
                {1'b1, expv(1, 2, 1), expv(11, 2, 2), expv(1, 12, 3)}) begin
                bad++;
                $display("FAIL stall_hold%0d got v=%b %h %h %h", i, valid_tri, vert1, vert2, vert3);
            end
            tick();
        end
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        total++;
        if (valid_tri !== 1'b0 || xfers - x0 != 1) begin
            bad++;
            $display("FAIL stall_release got valid=%b xfer=%0d want 0 1", valid_tri, xfers - x0);
        end
        ready_in = 1'b1;
        wait_done(40, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stall_done_timeout got=none want=obj_done");
        end
        tick();
        total++;
        if (dones - d0 != 1 || xfers - x0 != 2) begin
            bad++;
            $display("FAIL stall_counts got done=%0d xfer=%0d want 1 2", dones - d0, xfers - x0);
        end
    endtask

    task automatic test_ignore;
        int d0;
        int x0;
        bit ok;
        ready_in = 1'b1;
        d0 = dones;
        x0 = xfers;
        pulse_frame();
        tick();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        total++;
        if (mem_addr !== 3'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ignore_fetch got addr=%0d busy=%b want 2 1", mem_addr, busy);
        end
        wait_done(40, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ignore_done_timeout got=none want=obj_done");
        end
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_in_done got busy=%b want 0", busy);
        end
        for (int i = 0; i < 12; i++) tick();
        total++;
        if (busy !== 1'b0 || dones - d0 != 1 || xfers - x0 != 2) begin
            bad++;
            $display("FAIL ignore_counts got busy=%b done=%0d xfer=%0d want 0 1 2",
                     busy, dones - d0, xfers - x0);
        end
    endtask

    task automatic test_reset_present;
        int d0;
        bit ok;
        ready_in = 1'b0;
        d0 = dones;
        pulse_frame();
        wait_valid(20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstp_timeout got=none want=valid");
        end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        total++;
        if (valid_tri !== 1'b0 || busy !== 1'b0 || vert1 !== 27'd0) begin
            bad++;
            $display("FAIL rstp_state got valid=%b busy=%b v1=%h want 0 0 0", valid_tri, busy, vert1);
        end
        pulse_frame();
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (vert1 !== 27'd0 || vert2 !== 27'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstf_discard got v1=%h v2=%h busy=%b want 0 0 0", vert1, vert2, busy);
        end
        total++;
        if (dones != d0) begin
            bad++;
            $display("FAIL rst_no_done got=%0d want=%0d", dones, d0);
        end
    endtask

`ifdef TRI_FEEDER_BACKFACE_CULL_EN
    task automatic test_cull_mixed;
        int d0;
        int x0;
        bit ok;
        load_tri(0, 0, 0, 10, 0, 0, 10);
        load_tri(1, 0, 0, 0, 10, 10, 0);
        ready_in = 1'b1;
        d0 = dones;
        x0 = xfers;
        pulse_frame();
        wait_done(60, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cullmix_timeout got=none want=obj_done");
        end
        tick();
        total++;
        if (xfers - x0 != 1 || dones - d0 != 1) begin
            bad++;
            $display("FAIL cullmix_counts got xfer=%0d done=%0d want 1 1", xfers - x0, dones - d0);
        end
    endtask

    task automatic test_cull_all;
        int d0;
        int v0;
        bit ok;
        load_tri(0, 0, 0, 0, 10, 10, 0);
        load_tri(1, 1, 1, 2, 2, 3, 3);
        ready_in = 1'b1;
        d0 = dones;
        v0 = vcycles;
        pulse_frame();
        wait_done(60, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cullall_timeout got=none want=obj_done");
        end
        tick();
        total++;
        if (vcycles != v0 || dones - d0 != 1) begin
            bad++;
            $display("FAIL cullall_counts got vcyc=%0d done=%0d want 0 1", vcycles - v0, dones - d0);
        end
    endtask
`else
    task automatic test_no_cull;
        int x0;
        bit ok;
        load_tri(0, 0, 0, 0, 10, 10, 0);
        load_tri(1, 1, 1, 2, 2, 3, 3);
        ready_in = 1'b1;
        x0 = xfers;
        pulse_frame();
        wait_done(60, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL nocull_timeout got=none want=obj_done");
        end
        tick();
        total++;
        if (xfers - x0 != 2) begin
            bad++;
            $display("FAIL nocull_xfers got=%0d want=2", xfers - x0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_ignore();
        test_reset_present();
`ifdef TRI_FEEDER_BACKFACE_CULL_EN
        test_cull_mixed();
        test_cull_all();
`else
        test_no_cull();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tri_feeder.md
TRI_FEEDER -- requirements
Module: tri_feeder

Interface
REQ-001 SHALL have parameter NUM_TRIS, default 12, meaning triangles per object; legal range 1 and up.
REQ-002 SHALL have parameter MEM_LATENCY, default 2, meaning mesh-memory read latency in cycles.
REQ-003 SHALL have parameter ADDR_W, default $clog2(3*NUM_TRIS), meaning mesh-memory address width.
REQ-004 Port clk_in, input, 1, the single clock.
REQ-005 Port rst_in, input, 1, reset; synchronous and active-high.
REQ-006 Port new_frame, input, 1, request to stream the object once.
REQ-007 Port ready_in, input, 1, rasterizer ready.
REQ-008 Port mem_addr, output, ADDR_W, vertex word address.
REQ-009 Port mem_data, input, 27, vertex word {z[26:18], y[17:9], x[8:0]}.
REQ-010 Port vert1, output, [8:0] x [2:0], triangle vertex 1; the same format SHALL apply to vert2 and vert3.
REQ-011 Port valid_tri, output, 1, triangle presented.
REQ-012 Port obj_done, output, 1, single-cycle end-of-object pulse.
REQ-013 Port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 Vertex mapping SHALL be: vertN[0]=z, vertN[1]=y, vertN[2]=x.
REQ-015 The state machine SHALL have states IDLE, FETCH, CULL, PRESENT, DONE.
REQ-016 new_frame SHALL be honoured only in IDLE; in any other state it SHALL be ignored, not queued.
REQ-017 In IDLE, when new_frame=1 at cycle t: go to FETCH, set tri_idx=0, and drive mem_addr=3*tri_idx+k for k=0,1,2 in cycles t+1, t+2, t+3.
REQ-018 Each returned word SHALL be captured MEM_LATENCY cycles after its address into vert1, vert2 and vert3 in order.
REQ-019 After the third capture the block SHALL go to CULL for one cycle, then to PRESENT; valid_tri SHALL rise at t+4+MEM_LATENCY+1 (t+7 at defaults).
REQ-020 Handshake: a transfer SHALL occur on any cycle with valid_tri=1 and ready_in=1.
REQ-021 While valid_tri=1 and no transfer has occurred, vert1, vert2 and vert3 SHALL be held stable.
REQ-022 valid_tri SHALL fall in the cycle after a transfer.
REQ-023 After a transfer with tri_idx<NUM_TRIS-1, the block SHALL increment tri_idx and go to FETCH.
REQ-024 After a transfer on the last triangle, the block SHALL go to DONE.
REQ-025 DONE SHALL drive obj_done=1 for exactly one cycle, then return to IDLE.
REQ-026 A new_frame arriving in the same cycle as DONE SHALL be ignored.
REQ-027 tri_idx SHALL never wrap within an object; mem_addr SHALL never exceed 3*NUM_TRIS-1.
REQ-028 The valid_tri output SHALL be registered; ready_in SHALL have no combinational path to any output.

Reset
REQ-029 When rst_in=1, on the next clock edge the block SHALL set state=IDLE, tri_idx=0, valid_tri=0, obj_done=0, busy=0, mem_addr=0, and vert1, vert2 and vert3 to 0.
REQ-030 A reset asserted in any state SHALL abort the object with no obj_done pulse; in-flight memory data SHALL be discarded.

Configuration
REQ-031 With macro TRI_FEEDER_BACKFACE_CULL_EN defined, CULL SHALL compute A=(x2-x1)*(y3-y1)-(y2-y1)*(x3-x1) using 10-bit signed differences and a 21-bit signed result.
REQ-032 With that macro defined, a triangle with A<=0 SHALL skip PRESENT and proceed as if it had been transferred, going to FETCH or DONE.
REQ-033 Without that macro, CULL SHALL be a one-cycle pass-through to PRESENT and no triangle SHALL be skipped.
REQ-034 If every triangle of an object is culled, obj_done SHALL still pulse once.

Structure
REQ-035 The shared package SHALL hold the vertex typedef (3 x 9-bit), the 27-bit word field offsets, and the state enum.
REQ-036 No sub-module is required; the mesh memory (xilinx single-port ROM) SHALL be instantiated outside this block.

Verification
REQ-037 Reset, then NUM_TRIS=2, ready_in=1, pulse new_frame at t -> valid_tri=1 at t+7 with triangle 0 vertices, then triangle 1, then obj_done=1 for exactly one cycle; busy=0 afterwards.
REQ-038 ready_in held at 0 for 10 cycles while valid_tri=1 -> vert1, vert2, vert3 and valid_tri constant; exactly one transfer when ready_in rises.
REQ-039 new_frame pulsed during FETCH and during DONE -> ignored; exactly one obj_done per accepted frame.
REQ-040 rst_in asserted during PRESENT -> valid_tri=0 and busy=0 next cycle; no obj_done pulse.
REQ-041 With TRI_FEEDER_BACKFACE_CULL_EN, triangle 0 (0,0),(10,0),(0,10) with A=100 and triangle 1 clockwise with A=-100 -> only triangle 0 transferred, then obj_done.
REQ-042 With TRI_FEEDER_BACKFACE_CULL_EN and all triangles clockwise -> valid_tri never asserted; obj_done pulses once.
